// File: rtl/i3c_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i3c_pkg
// Brief    : Shared I3C controller types (PHY mode encoding).
// Revision : 1.0
// ============================================================================
package i3c_pkg;

  typedef enum logic [1:0] {
    I2C_CTRL = 2'd0,
    I3C_CTRL = 2'd1,
    I2C_TGT  = 2'd2,
    I3C_TGT  = 2'd3
  } phy_mode_e;

  localparam phy_mode_e c_phy_mode_rst = I3C_TGT;

endpackage
`default_nettype wire

// File: rtl/mode_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mode_switch_ctrl
// Brief    : Sequences PHY mux changes: drain bus, quiesce PHY, switch, settle.
// Revision : 1.0
// ============================================================================
module mode_switch_ctrl
  import i3c_pkg::*;
#(
  parameter int unsigned SettleCycles   = 8,
  parameter int unsigned QuiesceTimeout = 1023
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       bus_enable_i,
  input  logic       abort_i,
  input  logic [1:0] mode_req_i,
  input  logic       bus_idle_i,
  input  logic       quiesce_ack_i,
  output logic [1:0] phy_mux_select_o,
  output logic       phy_enable_o,
  output logic       quiesce_req_o,
  output logic       switching_o,
  output logic       timeout_err_o
);

  localparam int unsigned c_cnt_max = (SettleCycles > QuiesceTimeout) ? SettleCycles : QuiesceTimeout;
  localparam int unsigned c_cnt_w   = (c_cnt_max < 1) ? 1 : $clog2(c_cnt_max + 1);

  localparam logic [c_cnt_w-1:0] c_settle_load  = c_cnt_w'(SettleCycles);
  localparam logic [c_cnt_w-1:0] c_quiesce_load = c_cnt_w'(QuiesceTimeout);
  localparam logic [c_cnt_w-1:0] c_cnt_zero     = '0;
  localparam logic [c_cnt_w-1:0] c_cnt_one      = c_cnt_w'(1);

  localparam logic [2:0] c_st_disabled  = 3'd0;
  localparam logic [2:0] c_st_run       = 3'd1;
  localparam logic [2:0] c_st_wait_idle = 3'd2;
  localparam logic [2:0] c_st_quiesce   = 3'd3;
  localparam logic [2:0] c_st_switch    = 3'd4;
  localparam logic [2:0] c_st_settle    = 3'd5;

  logic [2:0]         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  phy_mode_e          r_mux;
  logic               r_phy_enable;
  logic               r_quiesce_req;
  logic               r_switching;
  logic               r_timeout_err;

  logic [2:0]         w_state_nxt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  phy_mode_e          w_mux_nxt;
  logic               w_timeout;
  logic               w_mode_diff;
  logic               w_cnt_last;

  assign w_mode_diff = (mode_req_i != r_mux);
  // The cycle that takes the counter to zero is the last one spent in the state.
  assign w_cnt_last  = (r_cnt <= c_cnt_one);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mux_nxt   = r_mux;
    w_timeout   = 1'b0;
    case (r_state)
      c_st_disabled: begin
        if (bus_enable_i && !abort_i) begin
          w_state_nxt = c_st_settle;
          w_cnt_nxt   = c_settle_load;
          w_mux_nxt   = phy_mode_e'(mode_req_i);
        end
      end
      c_st_settle: begin
        if (!bus_enable_i) begin
          w_state_nxt = c_st_disabled;
        end else if (w_cnt_last) begin
          w_state_nxt = c_st_run;
          w_cnt_nxt   = c_cnt_zero;
        end else begin
          w_cnt_nxt   = r_cnt - c_cnt_one;
        end
      end
      c_st_run: begin
        if (!bus_enable_i || w_mode_diff || abort_i) begin
          w_state_nxt = c_st_wait_idle;
        end
      end
      c_st_wait_idle: begin
        if (abort_i || bus_idle_i) begin
          w_state_nxt = c_st_quiesce;
          w_cnt_nxt   = c_quiesce_load;
        end else if (bus_enable_i && !w_mode_diff) begin
          w_state_nxt = c_st_run;
        end
      end
      c_st_quiesce: begin
        // An ack arriving on the expiry cycle suppresses the timeout.
        if (quiesce_ack_i) begin
          w_state_nxt = c_st_switch;
          w_cnt_nxt   = c_cnt_zero;
        end else if (w_cnt_last) begin
          w_state_nxt = c_st_switch;
          w_cnt_nxt   = c_cnt_zero;
          w_timeout   = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt - c_cnt_one;
        end
      end
      c_st_switch: begin
        if (bus_enable_i && !abort_i) begin
          w_state_nxt = c_st_settle;
          w_cnt_nxt   = c_settle_load;
          w_mux_nxt   = phy_mode_e'(mode_req_i);
        end else begin
          w_state_nxt = c_st_disabled;
        end
      end
      default: begin
        w_state_nxt = c_st_disabled;
        w_cnt_nxt   = c_cnt_zero;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= c_st_disabled;
      r_cnt         <= c_cnt_zero;
      r_mux         <= c_phy_mode_rst;
      r_phy_enable  <= 1'b0;
      r_quiesce_req <= 1'b0;
      r_switching   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_mux         <= w_mux_nxt;
      r_phy_enable  <= (w_state_nxt == c_st_run) || (w_state_nxt == c_st_wait_idle) ||
                       (w_state_nxt == c_st_quiesce);
      r_quiesce_req <= (w_state_nxt == c_st_quiesce);
      r_switching   <= (w_state_nxt != c_st_run) && (w_state_nxt != c_st_disabled);
      r_timeout_err <= w_timeout;
    end
  end

  assign phy_mux_select_o = r_mux;
  assign phy_enable_o     = r_phy_enable;
  assign quiesce_req_o    = r_quiesce_req;
  assign switching_o      = r_switching;
  assign timeout_err_o    = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_mode_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mode_switch_ctrl
// Brief    : Directed bench for mode_switch_ctrl with a phase/elapsed-time model.
// Revision : 1.0
// ============================================================================
module tb_mode_switch_ctrl;

  localparam int SC = 8;
  localparam int QT = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bus_en = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       idle = 1'b0;
  logic       ack = 1'b0;
  logic [1:0] mux;
  logic       en, qreq, sw, terr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mode_switch_ctrl #(.SettleCycles(SC), .QuiesceTimeout(QT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus_enable_i(bus_en), .abort_i(abort),
    .mode_req_i(mode), .bus_idle_i(idle), .quiesce_ack_i(ack),
    .phy_mux_select_o(mux), .phy_enable_o(en), .quiesce_req_o(qreq),
    .switching_o(sw), .timeout_err_o(terr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which phase the block is in and how many cycles it has been there.
  typedef enum {M_OFF, M_WARM, M_ON, M_DRAIN, M_STOP, M_SWAP} mph_t;
  mph_t       ph = M_OFF;
  int         el = 1;
  logic [1:0] m_mux = 2'd3;
  logic       m_terr = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    mph_t nph;
    if (!rst_n) begin
      ph = M_OFF; el = 1; m_mux = 2'd3; m_terr = 1'b0;
    end else begin
      nph = ph;
      m_terr = 1'b0;
      case (ph)
        M_OFF:   if (bus_en && !abort) begin nph = M_WARM; m_mux = mode; end
        M_WARM:  if (!bus_en) nph = M_OFF; else if (el >= SC) nph = M_ON;
        M_ON:    if (!bus_en || mode != m_mux || abort) nph = M_DRAIN;
        M_DRAIN: if (abort || idle) nph = M_STOP; else if (bus_en && mode == m_mux) nph = M_ON;
        M_STOP:  if (ack) nph = M_SWAP; else if (el >= QT) begin nph = M_SWAP; m_terr = 1'b1; end
        M_SWAP:  if (bus_en && !abort) begin nph = M_WARM; m_mux = mode; end else nph = M_OFF;
        default: nph = M_OFF;
      endcase
      el = (nph == ph) ? el + 1 : 1;
      ph = nph;
    end
  end

  // Per-cycle comparison plus observation counters used by directed checks.
  logic [1:0] prev_mux = 2'd3;
  logic       prev_en = 1'b0;
  int         qreq_cycles = 0, terr_pulses = 0;
  logic       en_dropped = 1'b0, qreq_seen = 1'b0, sw_seen = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("mux", mux, m_mux);
      check("phy_enable", en, ph inside {M_ON, M_DRAIN, M_STOP});
      check("quiesce_req", qreq, ph == M_STOP);
      check("switching", sw, !(ph inside {M_ON, M_OFF}));
      check("timeout_err", terr, m_terr);
      if (mux !== prev_mux) check("mux_change_while_enabled", {prev_en, en}, 0);
      if (qreq) qreq_cycles++;
      if (terr) terr_pulses++;
      if (!en) en_dropped = 1'b1;
      if (qreq) qreq_seen = 1'b1;
      if (sw) sw_seen = 1'b1;
    end
    prev_mux = mux;
    prev_en  = en;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_sig(input int which, input logic val, input int budget, output int n);
    logic s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      case (which)
        0:       s = en;
        1:       s = qreq;
        default: s = terr;
      endcase
    end while (s !== val && n < budget);
    if (s !== val) check($sformatf("wait_sig%0d_budget", which), s, val);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset values
    repeat (2) tick();
    check("rst_mux", mux, 2'd3);
    check("rst_en", en, 0);
    check("rst_qreq", qreq, 0);
    check("rst_sw", sw, 0);
    check("rst_terr", terr, 0);

    // Bring-up in I3C target mode
    rst_n = 1'b1; mode = 2'd3; bus_en = 1'b1;
    wait_sig(0, 1'b1, 30, n);
    check("bringup_latency", n, 9);
    check("bringup_mux", mux, 2'd3);

    // Mode change to I2C target with delayed idle and ack
    mode = 2'd2; idle = 1'b0;
    repeat (5) tick();
    idle = 1'b1;
    wait_sig(1, 1'b1, 20, n);
    check("mux_held_in_quiesce", mux, 2'd3);
    repeat (3) tick();
    ack = 1'b1;
    wait_sig(0, 1'b0, 10, n);
    ack = 1'b0; idle = 1'b0;
    wait_sig(0, 1'b1, 30, n);
    check("change_en_low_cycles", n, 9);
    check("change_mux", mux, 2'd2);

    // Cancel while waiting for idle
    en_dropped = 1'b0; qreq_seen = 1'b0; sw_seen = 1'b0;
    mode = 2'd1;
    repeat (2) tick();
    mode = 2'd2;
    repeat (4) tick();
    check("cancel_en_dropped", en_dropped, 0);
    check("cancel_qreq_seen", qreq_seen, 0);
    check("cancel_sw_seen", sw_seen, 1);
    check("cancel_mux", mux, 2'd2);
    check("cancel_running", sw, 0);

    // Quiesce timeout
    qreq_cycles = 0; terr_pulses = 0;
    mode = 2'd0; idle = 1'b1;
    wait_sig(1, 1'b1, 10, n);
    wait_sig(1, 1'b0, 40, n);
    check("timeout_at_switch", terr, 1);
    idle = 1'b0;
    wait_sig(0, 1'b1, 30, n);
    check("timeout_qreq_cycles", qreq_cycles, QT);
    check("timeout_pulses", terr_pulses, 1);
    check("timeout_mux", mux, 2'd0);

    // Abort with a pending mode request held off until abort clears
    abort = 1'b1; mode = 2'd1;
    repeat (2) tick();
    check("abort_quiesce", qreq, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    repeat (6) tick();
    check("abort_disabled_en", en, 0);
    check("abort_disabled_sw", sw, 0);
    check("abort_mux_kept", mux, 2'd0);
    abort = 1'b0;
    wait_sig(0, 1'b1, 30, n);
    check("abort_recover_latency", n, 9);
    check("abort_recover_mux", mux, 2'd1);

    // Ack on the same cycle the timeout would expire
    terr_pulses = 0;
    mode = 2'd2; idle = 1'b1;
    wait_sig(1, 1'b1, 10, n);
    repeat (QT - 1) tick();
    ack = 1'b1;
    tick();
    check("race_switched", qreq, 0);
    check("race_no_terr", terr, 0);
    ack = 1'b0; idle = 1'b0;
    wait_sig(0, 1'b1, 30, n);
    check("race_pulses", terr_pulses, 0);
    check("race_mux", mux, 2'd2);

    // Asynchronous reset in the middle of quiesce
    terr_pulses = 0;
    mode = 2'd0; idle = 1'b1;
    wait_sig(1, 1'b1, 10, n);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_mux", mux, 2'd3);
    check("midrst_en", en, 0);
    check("midrst_qreq", qreq, 0);
    check("midrst_sw", sw, 0);
    check("midrst_terr", terr, 0);
    repeat (3) tick();
    rst_n = 1'b1; idle = 1'b0;
    wait_sig(0, 1'b1, 30, n);
    check("midrst_recover_latency", n, 9);
    check("midrst_pulses", terr_pulses, 0);
    check("midrst_mux", mux, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mode_switch_ctrl.md
MODE_SWITCH_CTRL -- requirements
Module: mode_switch_ctrl

Interface
REQ-001 SHALL have parameter SettleCycles, default 8: cycles the PHY is held disabled after a mux change before re-enable.
REQ-002 SHALL have parameter QuiesceTimeout, default 1023: maximum cycles spent waiting for quiesce_ack_i.
REQ-003 clk_i  input  1  single clock; all state on its rising edge.
REQ-004 rst_ni  input  1  asynchronous active-low reset.
REQ-005 bus_enable_i  input  1  HC_CONTROL.BUS_ENABLE level.
REQ-006 abort_i  input  1  HC_CONTROL.ABORT level.
REQ-007 mode_req_i  input  2  requested PHY mode: 00 i2c ctrl, 01 i3c ctrl, 10 i2c target, 11 i3c target.
REQ-008 bus_idle_i  input  1  bus monitor reports bus free.
REQ-009 quiesce_ack_i  input  1  active PHY FSM has stopped at a safe point.
REQ-010 phy_mux_select_o  output  2  applied PHY mode.
REQ-011 phy_enable_o  output  1  enables the selected PHY.
REQ-012 quiesce_req_o  output  1  asks the active PHY to stop.
REQ-013 switching_o  output  1  high in any state other than RUN and DISABLED.
REQ-014 timeout_err_o  output  1  one-cycle pulse on quiesce timeout.

Function
REQ-015 The FSM SHALL have states DISABLED, RUN, WAIT_IDLE, QUIESCE, SWITCH and SETTLE; all outputs SHALL be registered.
REQ-016 DISABLED: phy_enable_o=0; on bus_enable_i=1, load mode_req_i into phy_mux_select_o, load counter=SettleCycles, go to SETTLE.
REQ-017 SETTLE: phy_enable_o=0; decrement counter each cycle; at counter==0 go to RUN; if bus_enable_i=0 go to DISABLED, with priority over the counter.
REQ-018 RUN: phy_enable_o=1; if bus_enable_i=0, mode_req_i!=phy_mux_select_o, or abort_i=1, go to WAIT_IDLE.
REQ-019 WAIT_IDLE: phy_enable_o=1.
- abort_i=1: go to QUIESCE immediately.
- Else bus_idle_i=1: go to QUIESCE.
- Else bus_enable_i=1 and mode_req_i==phy_mux_select_o: return to RUN (request cancelled).
- Priority: abort, then idle, then cancel.
REQ-020 QUIESCE: quiesce_req_o=1, phy_enable_o=1; load counter=QuiesceTimeout on entry; on quiesce_ack_i go to SWITCH; at counter==0 without ack, pulse timeout_err_o and go to SWITCH.
REQ-021 SWITCH lasts exactly one cycle with phy_enable_o=0 and quiesce_req_o=0.
- bus_enable_i=1 and abort_i=0: load mode_req_i into phy_mux_select_o, load counter=SettleCycles, go to SETTLE.
- Otherwise: keep phy_mux_select_o and go to DISABLED.
REQ-022 phy_mux_select_o SHALL change only in SWITCH or on the DISABLED->SETTLE transition, never while phy_enable_o=1.
REQ-023 When quiesce_ack_i and counter==0 occur in the same cycle, the ack SHALL win and no timeout_err_o pulse SHALL be produced.
REQ-024 While abort_i remains 1 after SWITCH, the block SHALL stay in DISABLED until abort_i=0 and bus_enable_i=1.
REQ-025 A single counter, width clog2(max(SettleCycles,QuiesceTimeout)+1), SHALL serve both SETTLE and QUIESCE; it saturates at 0 and never wraps.
REQ-026 A mode_req_i change during SETTLE SHALL be handled only after RUN is reached, via REQ-018.

Reset
REQ-027 On rst_ni=0 the block SHALL asynchronously enter DISABLED with phy_mux_select_o=2'b11, phy_enable_o=0, quiesce_req_o=0, switching_o=0, timeout_err_o=0, counter=0.
REQ-028 Reset asserted mid-operation, including in QUIESCE, SHALL abandon the sequence immediately with no timeout pulse.

Structure
REQ-029 The phy mode enum (I2C_CTRL=0, I3C_CTRL=1, I2C_TGT=2, I3C_TGT=3) SHALL live in i3c_pkg; the state enum is local to the module.
REQ-030 The block SHALL have no sub-module; it is one FSM plus the shared counter.

Verification
REQ-031 Bring-up: reset, then bus_enable_i=1 with mode_req_i=11 -> phy_enable_o rises exactly 9 cycles later (1 DISABLED->SETTLE cycle plus 8 settle cycles), mux=11.
REQ-032 Mode change: in RUN set mode_req_i=10, bus_idle_i=0 for 5 cycles then 1, ack 3 cycles after quiesce_req_o -> mux becomes 10 only in SWITCH, phy_enable_o=0 for 9 cycles, then RUN.
REQ-033 Timeout: QuiesceTimeout=15, quiesce_ack_i held 0 -> timeout_err_o pulses once after 15 cycles of quiesce_req_o, then switch completes.
REQ-034 Abort: in RUN with bus_idle_i=0, assert abort_i -> QUIESCE the next cycle; after ack, DISABLED with mux unchanged; RUN is not re-entered until abort_i=0.
REQ-035 Cancel: in WAIT_IDLE return mode_req_i to the current mode -> back to RUN with no quiesce_req_o, no mux change, and phy_enable_o never drops.
REQ-036 Race/reset: ack and counter==0 in the same cycle -> no timeout pulse; rst_ni low mid-QUIESCE -> all outputs at reset values asynchronously.
